// File: rtl/elu_arbiter_pkg.sv
// Shared constants for the elu_layer arbiter: FSM encodings, default timeout
// and a helper to size the RUN-cycle counter.
package elu_arbiter_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Default number of RUN cycles before a job is aborted with err
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  // Width of a counter that must be able to hold the value timeout
  function automatic int unsigned cnt_width(input int unsigned timeout);
    int unsigned w;
    w = (timeout < 1) ? 1 : $clog2(timeout + 1);
    return w;
  endfunction

endpackage

// File: rtl/elu_arbiter_rr_pick.sv
// Round-robin priority pick: first set bit of req searching upward from
// last+1, wrapping around, with last itself as the lowest priority.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned SELW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] last,
  output logic [SELW-1:0] winner,
  output logic            valid
);

  logic [SELW-1:0] idx;

  // Scan offsets NREQ..1 so the smallest offset (highest priority) is written last
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = SELW'((32'(last) + NREQ - k) % NREQ);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elu_arbiter.sv
// Arbiter sharing one elu_layer among NREQ requesters. A round-robin winner is
// picked in IDLE, owns the layer through RUN (elu_load high) and receives a
// one-cycle done or err pulse in DONE. All outputs are registered; sel drives
// the external operand mux.
module elu_arbiter
  import elu_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned SELW    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [SELW-1:0] sel,
  output logic            elu_load,
  input  logic            elu_valid,
  output logic [NREQ-1:0] done,
  output logic [NREQ-1:0] err,
  output logic            busy
);

  localparam int unsigned CW = cnt_width(TIMEOUT);

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SELW-1:0] last_q, last_d;
  logic [SELW-1:0] sel_d;
  logic [NREQ-1:0] grant_d, done_d, err_d;
  logic            load_d, busy_d;

  logic [SELW-1:0] win;
  logic            win_valid;
  logic            owner_req;
  logic            cnt_at_limit;

  rr_pick #(
    .NREQ (NREQ),
    .SELW (SELW)
  ) u_rr_pick (
    .req    (req),
    .last   (last_q),
    .winner (win),
    .valid  (win_valid)
  );

  // grant is one-hot, so masking req with it yields the owner's request bit
  assign owner_req    = |(req & grant);
  assign cnt_at_limit = (cnt_q == CW'(TIMEOUT));

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel;
    grant_d = grant;
    load_d  = elu_load;
    done_d  = '0;
    err_d   = '0;

    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        load_d  = 1'b0;
        if (win_valid) begin
          state_d = ST_RUN;
          grant_d = NREQ'(1) << win;
          sel_d   = win;
          load_d  = 1'b1;
          cnt_d   = '0;
        end
      end

      ST_RUN: begin
        if (!cnt_at_limit) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (!owner_req) begin
          // Owner withdrew: drop the job silently
          state_d = ST_IDLE;
          grant_d = '0;
          load_d  = 1'b0;
          last_d  = sel;
        end else if (elu_valid) begin
          // A result on the timeout cycle still counts as success
          state_d = ST_DONE;
          done_d  = grant;
          load_d  = 1'b0;
        end else if (cnt_at_limit) begin
          state_d = ST_DONE;
          err_d   = grant;
          load_d  = 1'b0;
        end
      end

      ST_DONE: begin
        // grant held through DONE so the owner sees its pulse with sel stable
        state_d = ST_IDLE;
        grant_d = '0;
        load_d  = 1'b0;
        last_d  = sel;
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        load_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_q   <= SELW'(NREQ - 1);
      grant    <= '0;
      sel      <= '0;
      elu_load <= 1'b0;
      done     <= '0;
      err      <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      grant    <= grant_d;
      sel      <= sel_d;
      elu_load <= load_d;
      done     <= done_d;
      err      <= err_d;
      busy     <= busy_d;
    end
  end

endmodule
